// File: rtl/host_responder.sv
// Host-side command responder: executes ping/write/read against a small word memory and returns status words.
// Latency: ping/write response 2 cycles after the last in-strobe, read 3 cycles then one word every 3 cycles.
// Backpressure: stalls in RESP/RD_SEND with outputs frozen while i_oh_ready is low; strobes outside IDLE/WR_DATA are dropped.
module host_responder #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        o_master_ready,
   input  logic        i_ih_reset,
   input  logic        i_ih_ready,
   input  logic [31:0] i_in_command,
   input  logic [31:0] i_in_address,
   input  logic [31:0] i_in_data,
   input  logic [27:0] i_in_data_count,
   input  logic        i_oh_ready,
   output logic        o_oh_en,
   output logic [31:0] o_out_status,
   output logic [31:0] o_out_address,
   output logic [31:0] o_out_data,
   output logic [27:0] o_out_data_count
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [15:0] OP_PING  = 16'h0000;
   localparam logic [15:0] OP_WRITE = 16'h0001;
   localparam logic [15:0] OP_READ  = 16'h0002;

   // ACK is the pulse cycle; it keeps the block out of IDLE so a strobe landing on the pulse is dropped
   typedef enum logic [2:0] {IDLE, WR_DATA, RESP, RD_FETCH, RD_SEND, ACK} state_t;

   state_t                state, state_n;
   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-1:0] base_q, ptr, wr_ptr;
   logic [27:0]           cnt_q, idx_q, eff_n;
   logic                  rd_q, wr_en;
   logic [15:0]           opcode;

   assign opcode         = i_in_command[15:0];
   assign eff_n          = (i_in_data_count == 28'd0) ? 28'd1 : i_in_data_count;
   assign ptr            = base_q + idx_q[ADDR_WIDTH-1:0];
   assign wr_ptr         = (state == IDLE) ? i_in_address[ADDR_WIDTH-1:0] : ptr;
   assign o_master_ready = (state == IDLE) || (state == WR_DATA);
   assign wr_en          = i_ih_ready && !i_ih_reset &&
                           (((state == IDLE) && (opcode == OP_WRITE)) || (state == WR_DATA));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (i_ih_ready) begin
               case (opcode)
                  OP_WRITE: state_n = (eff_n == 28'd1) ? RESP : WR_DATA;
                  OP_READ:  state_n = RD_FETCH;
                  default:  state_n = RESP;
               endcase
            end
         end
         WR_DATA:  if (i_ih_ready && (idx_q + 28'd1 == cnt_q)) state_n = RESP;
         RESP:     if (i_oh_ready) state_n = ACK;
         RD_FETCH: state_n = RD_SEND;
         RD_SEND:  if (i_oh_ready) state_n = ACK;
         ACK:      state_n = (rd_q && (idx_q != cnt_q)) ? RD_FETCH : IDLE;
         default:  state_n = IDLE;
      endcase
      if (i_ih_reset) state_n = IDLE;
   end

   // memory has no reset: contents survive both rst and i_ih_reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= i_in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_oh_en          <= 1'b0;
         o_out_status     <= '0;
         o_out_address    <= '0;
         o_out_data       <= '0;
         o_out_data_count <= '0;
         idx_q            <= '0;
         cnt_q            <= '0;
         base_q           <= '0;
         rd_q             <= 1'b0;
      end else if (i_ih_reset) begin
         o_oh_en          <= 1'b0;
         o_out_status     <= '0;
         o_out_address    <= '0;
         o_out_data       <= '0;
         o_out_data_count <= '0;
         idx_q            <= '0;
         cnt_q            <= '0;
         base_q           <= '0;
         rd_q             <= 1'b0;
      end else begin
         o_oh_en <= (state_n == ACK);
         case (state)
            IDLE: begin
               if (i_ih_ready) begin
                  base_q           <= i_in_address[ADDR_WIDTH-1:0];
                  cnt_q            <= eff_n;
                  idx_q            <= '0;
                  rd_q             <= (opcode == OP_READ);
                  o_out_address    <= i_in_address;
                  o_out_status     <= ~i_in_command;
                  o_out_data       <= '0;
                  o_out_data_count <= eff_n;
                  case (opcode)
                     OP_PING:  o_out_data_count <= '0;
                     OP_WRITE: begin
                        o_out_data <= i_in_data;
                        idx_q      <= 28'd1;
                     end
                     OP_READ:  ;
                     default: begin
                        o_out_status     <= 32'hEEEE_EEEE;
                        o_out_data_count <= '0;
                     end
                  endcase
               end
            end
            WR_DATA: begin
               if (i_ih_ready) begin
                  idx_q      <= idx_q + 28'd1;
                  o_out_data <= i_in_data;
               end
            end
            RD_FETCH: o_out_data <= mem[ptr];
            RD_SEND:  if (i_oh_ready) idx_q <= idx_q + 28'd1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_host_responder.sv
// Bench for host_responder: scoreboard of expected response words, per-feature tasks with inline checks.
module tb_host_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        o_master_ready;
   logic        i_ih_reset = 1'b0;
   logic        i_ih_ready = 1'b0;
   logic [31:0] i_in_command = '0;
   logic [31:0] i_in_address = '0;
   logic [31:0] i_in_data = '0;
   logic [27:0] i_in_data_count = '0;
   logic        i_oh_ready = 1'b1;
   logic        o_oh_en;
   logic [31:0] o_out_status, o_out_address, o_out_data;
   logic [27:0] o_out_data_count;

   typedef struct packed {
      logic [31:0] st;
      logic [31:0] ad;
      logic [31:0] da;
      logic [27:0] cn;
   } resp_t;

   resp_t exp_q[$];
   resp_t obs_q[$];
   int    obs_cyc[$];
   logic  obs_mr[$];
   int    cyc = 0;
   int    n_cmp = 0;
   int    n_bad = 0;
   int    t_strobe = 0;

   host_responder #(.ADDR_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .o_master_ready(o_master_ready),
      .i_ih_reset(i_ih_reset), .i_ih_ready(i_ih_ready),
      .i_in_command(i_in_command), .i_in_address(i_in_address),
      .i_in_data(i_in_data), .i_in_data_count(i_in_data_count),
      .i_oh_ready(i_oh_ready), .o_oh_en(o_oh_en),
      .o_out_status(o_out_status), .o_out_address(o_out_address),
      .o_out_data(o_out_data), .o_out_data_count(o_out_data_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && o_oh_en) begin
         obs_q.push_back(resp_t'({o_out_status, o_out_address, o_out_data, o_out_data_count}));
         obs_cyc.push_back(cyc);
         obs_mr.push_back(o_master_ready);
      end
   end

   function automatic resp_t mk(input logic [31:0] st, ad, da, input logic [27:0] cn);
      return resp_t'({st, ad, da, cn});
   endfunction

   task automatic strobe(input logic [31:0] c, a, d, input logic [27:0] n);
      @(negedge clk);
      i_in_command = c; i_in_address = a; i_in_data = d; i_in_data_count = n;
      i_ih_ready = 1'b1;
      t_strobe = cyc;
      @(negedge clk);
      i_ih_ready = 1'b0;
   endtask

   task automatic wait_obs(input int n);
      for (int i = 0; i < 60 && obs_q.size() < n; i++) @(negedge clk);
      repeat (4) @(negedge clk);
   endtask

   task automatic flush();
      exp_q.delete(); obs_q.delete(); obs_cyc.delete(); obs_mr.delete();
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({o_out_status, o_out_address, o_out_data, o_out_data_count} !== 124'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h %h %h %h, expected all zero",
                  o_out_status, o_out_address, o_out_data, o_out_data_count);
      end
      n_cmp++;
      if (o_master_ready !== 1'b1 || o_oh_en !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_handshake: master_ready=%b oh_en=%b, expected 1/0", o_master_ready, o_oh_en);
      end
   endtask

   task automatic test_ping();
      int ts;
      resp_t r, e;
      strobe(32'h0, 32'h12, 32'h99, 28'd7);
      ts = t_strobe;
      exp_q.push_back(mk(32'hFFFF_FFFF, 32'h12, 32'h0, 28'd0));
      // ts+2 is the pulse cycle: this strobe must be dropped
      @(negedge clk);
      i_in_command = 32'h7; i_ih_ready = 1'b1;
      @(negedge clk);
      i_ih_ready = 1'b0;
      wait_obs(1);
      repeat (6) @(negedge clk);
      n_cmp++;
      if (obs_q.size() != 1) begin
         n_bad++;
         $display("FAIL ping_count: got %0d responses, expected 1", obs_q.size());
      end
      if (obs_q.size() > 0) begin
         r = obs_q[0]; e = exp_q[0];
         n_cmp++;
         if (r !== e) begin n_bad++; $display("FAIL ping_resp: got %h, expected %h", r, e); end
         n_cmp++;
         if (obs_cyc[0] - ts != 2) begin
            n_bad++; $display("FAIL ping_latency: got %0d, expected 2", obs_cyc[0] - ts);
         end
         n_cmp++;
         if (obs_mr[0] !== 1'b0) begin
            n_bad++; $display("FAIL ping_master_ready_on_pulse: got %b, expected 0", obs_mr[0]);
         end
      end
      flush();
   endtask

   task automatic test_write_read();
      int tw, tr;
      resp_t r, e;
      strobe(32'h1, 32'd14, 32'hA1, 28'd3);
      strobe(32'hDEAD_0002, 32'h5, 32'hA2, 28'd9);
      strobe(32'h0, 32'h0, 32'hA3, 28'd0);
      tw = t_strobe;
      exp_q.push_back(mk(32'hFFFF_FFFE, 32'd14, 32'hA3, 28'd3));
      wait_obs(1);
      strobe(32'h2, 32'd14, 32'h0, 28'd3);
      tr = t_strobe;
      exp_q.push_back(mk(32'hFFFF_FFFD, 32'd14, 32'hA1, 28'd3));
      exp_q.push_back(mk(32'hFFFF_FFFD, 32'd14, 32'hA2, 28'd3));
      exp_q.push_back(mk(32'hFFFF_FFFD, 32'd14, 32'hA3, 28'd3));
      wait_obs(4);
      n_cmp++;
      if (obs_q.size() != 4) begin
         n_bad++; $display("FAIL wr_rd_count: got %0d responses, expected 4", obs_q.size());
      end else begin
         n_cmp++;
         if (obs_cyc[0] - tw != 2) begin
            n_bad++; $display("FAIL write_latency: got %0d, expected 2", obs_cyc[0] - tw);
         end
         n_cmp++;
         if (obs_cyc[1] - tr != 3 || obs_cyc[2] - obs_cyc[1] != 3 || obs_cyc[3] - obs_cyc[2] != 3) begin
            n_bad++;
            $display("FAIL read_timing: pulses at +%0d,+%0d,+%0d, expected +3,+6,+9",
                     obs_cyc[1] - tr, obs_cyc[2] - tr, obs_cyc[3] - tr);
         end
      end
      for (int i = 0; i < 4 && obs_q.size() > 0; i++) begin
         r = obs_q.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (r !== e) begin n_bad++; $display("FAIL wr_rd_resp[%0d]: got %h, expected %h", i, r, e); end
      end
      flush();
   endtask

   task automatic test_backpressure();
      logic [123:0] snap;
      logic stable = 1'b1;
      logic early = 1'b0;
      resp_t r, e;
      i_oh_ready = 1'b0;
      strobe(32'h2, 32'd14, 32'h0, 28'd2);
      @(negedge clk);
      snap = {o_out_status, o_out_address, o_out_data, o_out_data_count};
      repeat (8) begin
         @(negedge clk);
         if ({o_out_status, o_out_address, o_out_data, o_out_data_count} !== snap) stable = 1'b0;
         if (o_oh_en) early = 1'b1;
      end
      n_cmp++;
      if (early || obs_q.size() != 0) begin
         n_bad++; $display("FAIL bp_no_pulse: got %0d pulses while stalled, expected 0", obs_q.size());
      end
      n_cmp++;
      if (!stable) begin n_bad++; $display("FAIL bp_stable: got changing outputs, expected stable"); end
      i_oh_ready = 1'b1;
      exp_q.push_back(mk(32'hFFFF_FFFD, 32'd14, 32'hA1, 28'd2));
      exp_q.push_back(mk(32'hFFFF_FFFD, 32'd14, 32'hA2, 28'd2));
      wait_obs(2);
      n_cmp++;
      if (obs_q.size() != 2) begin
         n_bad++; $display("FAIL bp_count: got %0d responses, expected 2", obs_q.size());
      end else begin
         n_cmp++;
         if (obs_cyc[1] - obs_cyc[0] != 3) begin
            n_bad++; $display("FAIL bp_spacing: got %0d, expected 3", obs_cyc[1] - obs_cyc[0]);
         end
      end
      for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
         r = obs_q.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (r !== e) begin n_bad++; $display("FAIL bp_resp[%0d]: got %h, expected %h", i, r, e); end
      end
      flush();
   endtask

   task automatic test_zero_count_and_unknown();
      resp_t r, e;
      strobe(32'h1, 32'd3, 32'h55, 28'd0);
      exp_q.push_back(mk(32'hFFFF_FFFE, 32'd3, 32'h55, 28'd1));
      wait_obs(1);
      strobe(32'h2, 32'd3, 32'h0, 28'd1);
      exp_q.push_back(mk(32'hFFFF_FFFD, 32'd3, 32'h55, 28'd1));
      wait_obs(2);
      strobe(32'h7, 32'h20, 32'h99, 28'd5);
      exp_q.push_back(mk(32'hEEEE_EEEE, 32'h20, 32'h0, 28'd0));
      wait_obs(3);
      n_cmp++;
      if (obs_q.size() != 3) begin
         n_bad++; $display("FAIL n0_unknown_count: got %0d responses, expected 3", obs_q.size());
      end
      for (int i = 0; i < 3 && obs_q.size() > 0; i++) begin
         r = obs_q.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (r !== e) begin n_bad++; $display("FAIL n0_unknown_resp[%0d]: got %h, expected %h", i, r, e); end
      end
      flush();
   endtask

   task automatic test_abort();
      resp_t r, e;
      strobe(32'h1, 32'd5, 32'hB1, 28'd4);
      strobe(32'h0, 32'h0, 32'hB2, 28'd0);
      @(negedge clk);
      i_ih_reset = 1'b1;
      @(negedge clk);
      i_ih_reset = 1'b0;
      n_cmp++;
      if ({o_out_status, o_out_address, o_out_data, o_out_data_count} !== 124'd0 || o_master_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL soft_abort: got status=%h data=%h master_ready=%b, expected 0/0/1",
                  o_out_status, o_out_data, o_master_ready);
      end
      repeat (5) @(negedge clk);
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_bad++; $display("FAIL soft_abort_pulse: got %0d pulses, expected 0", obs_q.size());
      end
      flush();
      strobe(32'h2, 32'd5, 32'h0, 28'd2);
      exp_q.push_back(mk(32'hFFFF_FFFD, 32'd5, 32'hB1, 28'd2));
      exp_q.push_back(mk(32'hFFFF_FFFD, 32'd5, 32'hB2, 28'd2));
      wait_obs(2);
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++; $display("FAIL abort_kept[%0d]: got no response, expected %h", i, exp_q[0]);
            exp_q.pop_front();
         end else begin
            r = obs_q.pop_front(); e = exp_q.pop_front();
            if (r !== e) begin n_bad++; $display("FAIL abort_kept[%0d]: got %h, expected %h", i, r, e); end
         end
      end
      flush();
      // hard reset while stalled mid-read
      i_oh_ready = 1'b0;
      strobe(32'h2, 32'd14, 32'h0, 28'd3);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if ({o_out_status, o_out_address, o_out_data, o_out_data_count} !== 124'd0 || o_master_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL hard_abort: got status=%h data=%h master_ready=%b, expected 0/0/1",
                  o_out_status, o_out_data, o_master_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      i_oh_ready = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_bad++; $display("FAIL hard_abort_pulse: got %0d pulses, expected 0", obs_q.size());
      end
      flush();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_ping();
      test_write_read();
      test_backpressure();
      test_zero_count_and_unknown();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
